// File: rtl/sargantana_icache_pkg.sv
// rtl/sargantana_icache_pkg.sv - shared sizes and FSM encoding for the iFill responder
package sargantana_icache_pkg;

  localparam int IFILL_PADDR_SIZE = 40;
  localparam int IFILL_LINE_BITS  = 512;
  localparam int IFILL_BEAT_BITS  = 128;
  localparam int IFILL_BEATS      = IFILL_LINE_BITS / IFILL_BEAT_BITS;
  localparam int IFILL_CNT_W      = $clog2(IFILL_BEATS);
  localparam int IFILL_OFS_W      = $clog2(IFILL_LINE_BITS / 8);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RECV,
    RESP
  } ifill_rsp_state_t;

endpackage

// File: rtl/sargantana_ifill_responder_if.sv
// rtl/sargantana_ifill_responder_if.sv - icache fill request/response and memory burst signals
interface sargantana_ifill_responder_if
  import sargantana_icache_pkg::*;
#(
  parameter int PADDR_SIZE = IFILL_PADDR_SIZE,
  parameter int LINE_BITS  = IFILL_LINE_BITS,
  parameter int BEAT_BITS  = IFILL_BEAT_BITS
) ();

  logic                  ifill_req_valid_i;
  logic [PADDR_SIZE-1:0] ifill_req_paddr_i;
  logic                  ifill_resp_valid_o;
  logic                  ifill_resp_ack_o;
  logic [LINE_BITS-1:0]  ifill_resp_data_o;
  logic                  ifill_resp_inv_valid_o;
  logic [PADDR_SIZE-1:0] ifill_resp_inv_paddr_o;
  logic                  mem_req_valid_o;
  logic                  mem_req_ready_i;
  logic [PADDR_SIZE-1:0] mem_req_addr_o;
  logic                  mem_resp_valid_i;
  logic [BEAT_BITS-1:0]  mem_resp_data_i;

  modport slave (
    input  ifill_req_valid_i, ifill_req_paddr_i,
    input  mem_req_ready_i, mem_resp_valid_i, mem_resp_data_i,
    output ifill_resp_valid_o, ifill_resp_ack_o, ifill_resp_data_o,
    output ifill_resp_inv_valid_o, ifill_resp_inv_paddr_o,
    output mem_req_valid_o, mem_req_addr_o
  );

  modport master (
    output ifill_req_valid_i, ifill_req_paddr_i,
    output mem_req_ready_i, mem_resp_valid_i, mem_resp_data_i,
    input  ifill_resp_valid_o, ifill_resp_ack_o, ifill_resp_data_o,
    input  ifill_resp_inv_valid_o, ifill_resp_inv_paddr_o,
    input  mem_req_valid_o, mem_req_addr_o
  );

endinterface

// File: rtl/ifill_line_assembler.sv
// rtl/ifill_line_assembler.sv - beat counter and line register assembling one refill line
module ifill_line_assembler
  import sargantana_icache_pkg::*;
#(
  parameter int LINE_BITS = IFILL_LINE_BITS,
  parameter int BEAT_BITS = IFILL_BEAT_BITS
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 clr_i,
  input  logic                 beat_valid_i,
  input  logic [BEAT_BITS-1:0] beat_i,
  output logic [LINE_BITS-1:0] line_o,
  output logic                 last_o
);

  localparam int BEATS = LINE_BITS / BEAT_BITS;
  localparam int CNT_W = $clog2(BEATS);

  logic [CNT_W-1:0]     r_cnt;
  logic [LINE_BITS-1:0] r_line;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_cnt <= '0;
    end else if (clr_i) begin
      r_cnt <= '0;
    end else if (beat_valid_i) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // The line is not cleared between fills so the last line stays visible.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_line <= '0;
    end else if (beat_valid_i) begin
      for (int b = 0; b < BEATS; b++) begin
        if (r_cnt == CNT_W'(b)) begin
          r_line[b*BEAT_BITS +: BEAT_BITS] <= beat_i;
        end
      end
    end
  end

  assign line_o = r_line;
  assign last_o = beat_valid_i && (r_cnt == CNT_W'(BEATS - 1));

endmodule

// File: rtl/sargantana_ifill_responder.sv
// rtl/sargantana_ifill_responder.sv - icache refill responder: one memory burst per line fill
// Optional coherence invalidation path is built when IFILL_INV_EN is defined.
module sargantana_ifill_responder
  import sargantana_icache_pkg::*;
#(
  parameter int PADDR_SIZE = IFILL_PADDR_SIZE,
  parameter int LINE_BITS  = IFILL_LINE_BITS,
  parameter int BEAT_BITS  = IFILL_BEAT_BITS
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
`ifdef IFILL_INV_EN
  input  logic                  inv_valid_i,
  input  logic [PADDR_SIZE-1:0] inv_paddr_i,
`endif
  sargantana_ifill_responder_if.slave ifill_if
);

  localparam int OFS_W = $clog2(LINE_BITS / 8);
  localparam logic [PADDR_SIZE-1:0] OFS_MASK = PADDR_SIZE'((64'd1 << OFS_W) - 64'd1);

  ifill_rsp_state_t      r_state;
  ifill_rsp_state_t      w_state_nxt;
  logic                  r_killed;
  logic                  r_after_resp;
  logic [PADDR_SIZE-1:0] r_addr;
  logic                  w_accept;
  logic                  w_mem_req_valid;
  logic                  w_beat_valid;
  logic                  w_resp_fire;
  logic                  w_last;
  logic [LINE_BITS-1:0]  w_line;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (ifill_if.ifill_req_valid_i && !r_after_resp) w_state_nxt = REQ;
      REQ:     if (ifill_if.mem_req_ready_i) w_state_nxt = RECV;
      RECV:    if (w_last) w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Beats are only taken in RECV, so a beat alongside ready or after a reset is dropped.
  always_comb begin
    w_accept        = 1'b0;
    w_mem_req_valid = 1'b0;
    w_beat_valid    = 1'b0;
    w_resp_fire     = 1'b0;
    case (r_state)
      IDLE:    w_accept        = ifill_if.ifill_req_valid_i && !r_after_resp;
      REQ:     w_mem_req_valid = 1'b1;
      RECV:    w_beat_valid    = ifill_if.mem_resp_valid_i;
      RESP:    w_resp_fire     = !r_killed;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_addr       <= '0;
      r_killed     <= 1'b0;
      r_after_resp <= 1'b0;
    end else begin
      r_after_resp <= (r_state == RESP);
      if (w_accept) begin
        r_addr <= ifill_if.ifill_req_paddr_i & ~OFS_MASK;
      end
      if (r_state == IDLE) begin
        r_killed <= 1'b0;
      end else if ((r_state == REQ || r_state == RECV) && !ifill_if.ifill_req_valid_i) begin
        r_killed <= 1'b1;
      end
    end
  end

  ifill_line_assembler #(
    .LINE_BITS (LINE_BITS),
    .BEAT_BITS (BEAT_BITS)
  ) u_assembler (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .clr_i        (w_accept),
    .beat_valid_i (w_beat_valid),
    .beat_i       (ifill_if.mem_resp_data_i),
    .line_o       (w_line),
    .last_o       (w_last)
  );

  assign ifill_if.mem_req_valid_o    = w_mem_req_valid;
  assign ifill_if.mem_req_addr_o     = r_addr;
  assign ifill_if.ifill_resp_valid_o = w_resp_fire;
  assign ifill_if.ifill_resp_ack_o   = w_resp_fire;
  assign ifill_if.ifill_resp_data_o  = w_line;

`ifdef IFILL_INV_EN
  logic                  r_inv_valid;
  logic [PADDR_SIZE-1:0] r_inv_paddr;
  logic                  r_pend_valid;
  logic [PADDR_SIZE-1:0] r_pend_paddr;
  logic                  w_match;
  logic                  w_direct;
  logic                  w_release_ok;

  // An inv hitting the line being filled must reach the icache after the fill lands.
  assign w_match      = inv_valid_i && (r_state != IDLE) && ((inv_paddr_i & ~OFS_MASK) == r_addr);
  assign w_direct     = inv_valid_i && !w_match;
  assign w_release_ok = (r_state == RESP) || (r_state == IDLE);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_inv_valid  <= 1'b0;
      r_inv_paddr  <= '0;
      r_pend_valid <= 1'b0;
      r_pend_paddr <= '0;
    end else begin
      r_inv_valid <= 1'b0;
      if (w_direct) begin
        r_inv_valid <= 1'b1;
        r_inv_paddr <= inv_paddr_i;
      end else if (w_release_ok && (r_pend_valid || w_match)) begin
        r_inv_valid  <= 1'b1;
        r_inv_paddr  <= w_match ? inv_paddr_i : r_pend_paddr;
        r_pend_valid <= 1'b0;
      end else if (w_match) begin
        r_pend_valid <= 1'b1;
        r_pend_paddr <= inv_paddr_i;
      end
    end
  end

  assign ifill_if.ifill_resp_inv_valid_o = r_inv_valid;
  assign ifill_if.ifill_resp_inv_paddr_o = r_inv_paddr;
`else
  assign ifill_if.ifill_resp_inv_valid_o = 1'b0;
  assign ifill_if.ifill_resp_inv_paddr_o = '0;
`endif

endmodule

// File: tb/tb_sargantana_ifill_responder.sv
// tb/tb_sargantana_ifill_responder.sv - vector table plus scoreboard bench for the iFill responder
module tb_sargantana_ifill_responder;

  localparam int PA = 40;
  localparam int LB = 512;
  localparam int BB = 128;
  localparam int NB = LB / BB;
  localparam logic [PA-1:0] LMASK = 40'h3F;

  typedef struct {
    logic [PA-1:0] paddr;
    int            rdly;
    int            gap;
    int            kill_beat;
    logic          inv_en;
    logic [PA-1:0] inv_addr;
    logic          hold;
    logic [PA-1:0] exp_addr;
  } vec_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  logic [LB-1:0] sb_q[$];
  vec_t vecs[7];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sargantana_ifill_responder_if #(.PADDR_SIZE(PA), .LINE_BITS(LB), .BEAT_BITS(BB)) bus ();

`ifdef IFILL_INV_EN
  logic          inv_valid;
  logic [PA-1:0] inv_paddr;
`endif

  sargantana_ifill_responder #(
    .PADDR_SIZE (PA),
    .LINE_BITS  (LB),
    .BEAT_BITS  (BB)
  ) dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
`ifdef IFILL_INV_EN
    .inv_valid_i (inv_valid),
    .inv_paddr_i (inv_paddr),
`endif
    .ifill_if    (bus)
  );

  task automatic check(input string name, input logic [LB-1:0] act, input logic [LB-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rstn && bus.ifill_resp_valid_o === 1'b1) begin
      if (sb_q.size() == 0) check("resp_unexpected", 1, 0);
      else check("resp_data", bus.ifill_resp_data_o, sb_q.pop_front());
    end
  end

  task automatic run_fill(input vec_t v, input logic [PA-1:0] next_paddr);
    logic [BB-1:0] beats[NB];
    logic [LB-1:0] line;
    logic          killed;
    logic          inv_match;
    int            c0;
    int            waited;
    killed    = (v.kill_beat >= 0);
    inv_match = v.inv_en && ((v.inv_addr & ~LMASK) == v.exp_addr);
    for (int b = 0; b < NB; b++) begin
      beats[b] = {$urandom, $urandom, $urandom, $urandom};
      line[b*BB +: BB] = beats[b];
    end
    bus.ifill_req_valid_i = 1'b1;
    bus.ifill_req_paddr_i = v.paddr;
    c0 = cyc;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (bus.mem_req_valid_o !== 1'b1 && waited < 10);
    check("mem_req_seen", bus.mem_req_valid_o, 1);
    if (bus.mem_req_valid_o !== 1'b1) begin
      bus.ifill_req_valid_i = 1'b0;
      return;
    end
    check("mem_req_addr", bus.mem_req_addr_o, v.exp_addr);
    for (int i = 0; i < v.rdly; i++) begin
      @(negedge clk);
      check("mem_req_hold", {bus.mem_req_valid_o, bus.mem_req_addr_o}, {1'b1, v.exp_addr});
    end
    bus.mem_req_ready_i = 1'b1;
    @(negedge clk);
    bus.mem_req_ready_i = 1'b0;
    for (int b = 0; b < NB; b++) begin
      for (int g = 0; g < ((b == 0) ? 0 : v.gap); g++) begin
        bus.mem_resp_valid_i = 1'b0;
        @(negedge clk);
        check("gap_quiet", {bus.mem_req_valid_o, bus.ifill_resp_valid_o}, 2'b00);
      end
      bus.mem_resp_valid_i = 1'b1;
      bus.mem_resp_data_i  = beats[b];
      if (killed && b > v.kill_beat) bus.ifill_req_valid_i = 1'b0;
`ifdef IFILL_INV_EN
      if (v.inv_en && b == 1) begin
        inv_valid = 1'b1;
        inv_paddr = v.inv_addr;
      end
`endif
      if (b == NB - 1 && !killed) sb_q.push_back(line);
      @(negedge clk);
`ifdef IFILL_INV_EN
      if (inv_valid) begin
        inv_valid = 1'b0;
        check("inv_direct_valid", bus.ifill_resp_inv_valid_o, !inv_match);
        if (!inv_match) check("inv_direct_paddr", bus.ifill_resp_inv_paddr_o, v.inv_addr);
      end
`endif
      if (b < NB - 1) check("no_early_ack", bus.ifill_resp_valid_o, 0);
    end
    bus.mem_resp_valid_i = 1'b0;
    check("ack_latency", cyc - c0, 2 + NB + v.rdly + (NB - 1) * v.gap);
    check("ack_flags", {bus.ifill_resp_valid_o, bus.ifill_resp_ack_o}, killed ? 2'b00 : 2'b11);
    if (v.hold) bus.ifill_req_paddr_i = next_paddr;
    else bus.ifill_req_valid_i = 1'b0;
    @(negedge clk);
    check("ack_pulse", {bus.ifill_resp_valid_o, bus.ifill_resp_ack_o}, 2'b00);
`ifdef IFILL_INV_EN
    check("inv_after_fill", bus.ifill_resp_inv_valid_o, inv_match);
    if (inv_match) check("inv_after_paddr", bus.ifill_resp_inv_paddr_o, v.inv_addr);
`else
    check("inv_tied_off", {bus.ifill_resp_inv_valid_o, bus.ifill_resp_inv_paddr_o}, 0);
`endif
    check("ignore_after_resp", bus.mem_req_valid_o, 0);
    @(negedge clk);
    check("req_gap", bus.mem_req_valid_o, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{40'h80_0000_1234, 0, 0, -1, 1'b1, 40'h80_0000_1200, 1'b0, 40'h80_0000_1200};
    vecs[1] = '{40'h12_3456_78FF, 5, 3, -1, 1'b1, 40'h00_0000_9000, 1'b0, 40'h12_3456_78C0};
    vecs[2] = '{40'h80_0000_2040, 0, 0,  1, 1'b0, 40'h0,            1'b0, 40'h80_0000_2040};
    vecs[3] = '{40'h00_0000_1000, 0, 0, -1, 1'b0, 40'h0,            1'b0, 40'h00_0000_1000};
    vecs[4] = '{40'hFF_FFFF_FFFF, 1, 1, -1, 1'b0, 40'h0,            1'b1, 40'hFF_FFFF_FFC0};
    vecs[5] = '{40'h00_0000_003F, 2, 0,  0, 1'b0, 40'h0,            1'b0, 40'h00_0000_0000};
    vecs[6] = '{40'h00_0000_7FC1, 0, 2, -1, 1'b0, 40'h0,            1'b0, 40'h00_0000_7FC0};

    bus.ifill_req_valid_i = 1'b0;
    bus.ifill_req_paddr_i = '0;
    bus.mem_req_ready_i   = 1'b0;
    bus.mem_resp_valid_i  = 1'b0;
    bus.mem_resp_data_i   = '0;
`ifdef IFILL_INV_EN
    inv_valid = 1'b0;
    inv_paddr = '0;
`endif
    repeat (2) @(negedge clk);
    check("rst_mem_req", {bus.mem_req_valid_o, bus.mem_req_addr_o}, 0);
    check("rst_resp", {bus.ifill_resp_valid_o, bus.ifill_resp_ack_o}, 0);
    check("rst_data", bus.ifill_resp_data_o, 0);
    check("rst_inv", {bus.ifill_resp_inv_valid_o, bus.ifill_resp_inv_paddr_o}, 0);
    rstn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run_fill(vecs[i], (i < 6) ? vecs[i+1].paddr : '0);
    end

    // Reset in the middle of RECV, with memory still streaming afterwards.
    bus.ifill_req_valid_i = 1'b1;
    bus.ifill_req_paddr_i = 40'h00_0000_4440;
    @(negedge clk);
    check("rst_seq_req", bus.mem_req_valid_o, 1);
    bus.mem_req_ready_i = 1'b1;
    @(negedge clk);
    bus.mem_req_ready_i = 1'b0;
    for (int b = 0; b < 2; b++) begin
      bus.mem_resp_valid_i = 1'b1;
      bus.mem_resp_data_i  = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
    end
    rstn = 1'b0;
    bus.ifill_req_valid_i = 1'b0;
    #1;
    check("midrst_mem_req", {bus.mem_req_valid_o, bus.mem_req_addr_o}, 0);
    check("midrst_resp", {bus.ifill_resp_valid_o, bus.ifill_resp_ack_o}, 0);
    check("midrst_data", bus.ifill_resp_data_o, 0);
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("stray_ignored", {bus.mem_req_valid_o, bus.ifill_resp_valid_o}, 2'b00);
    end
    check("stray_data", bus.ifill_resp_data_o, 0);
    bus.mem_resp_valid_i = 1'b0;
    @(negedge clk);
    run_fill(vecs[1], '0);

    check("scoreboard_empty", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
